// File: rtl/hazard_if.sv
// Hazard-unit signal bundle: pipeline-stage operand/destination info in, stall/flush/redirect
// controls and the interrupt/performance state out. The core drives it (master); the unit sinks it (slave).
interface hazard_if #(
  parameter int REG_W  = 4,
  parameter int NSRC   = 2,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic                    int_req_i;
  logic [ADDR_W-1:0]       epc_i;
  logic                    ram2_conflict_i;
  logic                    memread_ex_i;
  logic [REG_W-1:0]        regdst_ex_i;
  logic                    memread_mem_i;
  logic [REG_W-1:0]        regdst_mem_i;
  logic [NSRC*REG_W-1:0]   regsrc_id_i;
  logic [NSRC-1:0]         srcvalid_id_i;
  logic                    isjump_i;
  logic                    isbranch_i;
  logic                    prediction_i;
  logic                    ifbranch_i;
  logic                    stall_pc_o;
  logic                    stall_if_o;
  logic                    flush_if_o;
  logic                    flush_id_o;
  logic                    flush_ex_o;
  logic                    jr_o;
  logic                    prewrong_o;
  logic                    precorrc_o;
  logic                    isintzero_o;
  logic                    int_ack_o;
  logic [ADDR_W-1:0]       epc_o;
  logic [CNT_W-1:0]        stall_cnt_o;
  logic [CNT_W-1:0]        mispred_cnt_o;

  modport master (
    output int_req_i, epc_i, ram2_conflict_i, memread_ex_i, regdst_ex_i,
           memread_mem_i, regdst_mem_i, regsrc_id_i, srcvalid_id_i,
           isjump_i, isbranch_i, prediction_i, ifbranch_i,
    input  stall_pc_o, stall_if_o, flush_if_o, flush_id_o, flush_ex_o, jr_o,
           prewrong_o, precorrc_o, isintzero_o, int_ack_o, epc_o,
           stall_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  int_req_i, epc_i, ram2_conflict_i, memread_ex_i, regdst_ex_i,
           memread_mem_i, regdst_mem_i, regsrc_id_i, srcvalid_id_i,
           isjump_i, isbranch_i, prediction_i, ifbranch_i,
    output stall_pc_o, stall_if_o, flush_if_o, flush_id_o, flush_ex_o, jr_o,
           prewrong_o, precorrc_o, isintzero_o, int_ack_o, epc_o,
           stall_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/hazard_unit_p.sv
// Pipeline hazard/interrupt controller: load-use and jr/branch-vs-load detection, multi-cycle
// load stalls, edge-armed interrupt FSM with EPC capture, saturating stall/mispredict counters.
module hazard_unit_p #(
  parameter int REG_W      = 4,
  parameter int NSRC       = 2,
  parameter int ADDR_W     = 16,
  parameter int LOAD_STALL = 1,
  parameter int INT_FLUSH  = 1,
  parameter int CNT_W      = 16
) (
  input  logic    CLK,
  input  logic    RST,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_INT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LS_INIT = 3'(LOAD_STALL - 1);
  localparam logic [2:0]       IF_INIT = 3'(INT_FLUSH);

  state_t              state;
  logic [2:0]          cnt;
  logic                armed;
  logic [ADDR_W-1:0]   epc;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    mispred_cnt;

  logic lu_hit;
  logic jb_hit;
  logic in_int;
  logic int_take;
  logic stall;
  logic prewrong;
  logic precorrc;
  logic jr;

  // Hazard detection and stall/redirect priority (interrupt > stall > redirect)
  always_comb begin
    lu_hit = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (hz.memread_ex_i && hz.srcvalid_id_i[k] &&
          (hz.regsrc_id_i[k*REG_W +: REG_W] == hz.regdst_ex_i)) begin
        lu_hit = 1'b1;
      end else begin
        lu_hit = lu_hit;
      end
    end
    jb_hit   = (hz.isjump_i | hz.isbranch_i) & hz.memread_mem_i & hz.srcvalid_id_i[0] &
               (hz.regsrc_id_i[REG_W-1:0] == hz.regdst_mem_i);
    in_int   = (state == ST_INT);
    int_take = ~in_int & hz.int_req_i & armed;
    stall    = (lu_hit | jb_hit | hz.ram2_conflict_i | (state == ST_LSTALL)) & ~in_int & ~int_take;
    prewrong = hz.isbranch_i & (hz.prediction_i ^ hz.ifbranch_i) & ~stall & ~int_take;
    precorrc = hz.isbranch_i & ~(hz.prediction_i ^ hz.ifbranch_i) & ~stall & ~int_take;
    jr       = hz.isjump_i & ~stall & ~int_take;
  end

  // Output drive; everything reads as zero while reset is asserted
  always_comb begin
    hz.stall_pc_o    = 1'b0;
    hz.stall_if_o    = 1'b0;
    hz.flush_if_o    = 1'b0;
    hz.flush_id_o    = 1'b0;
    hz.flush_ex_o    = 1'b0;
    hz.jr_o          = 1'b0;
    hz.prewrong_o    = 1'b0;
    hz.precorrc_o    = 1'b0;
    hz.isintzero_o   = 1'b0;
    hz.int_ack_o     = 1'b0;
    hz.epc_o         = '0;
    hz.stall_cnt_o   = '0;
    hz.mispred_cnt_o = '0;
    if (RST) begin
      hz.epc_o = '0;
    end else begin
      hz.stall_pc_o    = stall;
      hz.stall_if_o    = stall;
      hz.flush_if_o    = prewrong | jr | int_take;
      hz.flush_id_o    = stall | in_int | int_take;
      hz.flush_ex_o    = in_int;
      hz.jr_o          = jr;
      hz.prewrong_o    = prewrong;
      hz.precorrc_o    = precorrc;
      hz.isintzero_o   = in_int;
      hz.int_ack_o     = int_take;
      hz.epc_o         = epc;
      hz.stall_cnt_o   = stall_cnt;
      hz.mispred_cnt_o = mispred_cnt;
    end
  end

  // Control FSM, EPC capture, interrupt re-arm and performance counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_RUN;
      cnt         <= 3'd0;
      armed       <= 1'b1;
      epc         <= '0;
      stall_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      // A request held across the flush window must drop before it can be taken again
      if (!hz.int_req_i) begin
        armed <= 1'b1;
      end else if (int_take) begin
        armed <= 1'b0;
      end else begin
        armed <= armed;
      end

      case (state)
        ST_RUN: begin
          if (int_take) begin
            state <= ST_INT;
            cnt   <= IF_INIT;
            epc   <= hz.epc_i;
          end else if ((LOAD_STALL > 1) && lu_hit) begin
            state <= ST_LSTALL;
            cnt   <= LS_INIT;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_LSTALL: begin
          if (int_take) begin
            state <= ST_INT;
            cnt   <= IF_INIT;
            epc   <= hz.epc_i;
          end else if (cnt == 3'd1) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
          end else begin
            cnt   <= cnt - 3'd1;
          end
        end
        ST_INT: begin
          if (cnt == 3'd1) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
          end else begin
            cnt   <= cnt - 3'd1;
          end
        end
        default: begin
          state <= ST_RUN;
          cnt   <= 3'd0;
        end
      endcase

      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end

      if (prewrong && (mispred_cnt != CNT_MAX)) begin
        mispred_cnt <= mispred_cnt + CNT_ONE;
      end else begin
        mispred_cnt <= mispred_cnt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_p.sv
// Directed bench for hazard_unit_p: three instances (LOAD_STALL=1, LOAD_STALL=3/INT_FLUSH=2, NSRC=3).
// Flag vector order: stall_pc stall_if flush_if flush_id flush_ex jr prewrong precorrc isintzero int_ack.
module tb_hazard_unit_p;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  hazard_if #(.REG_W(4), .NSRC(2), .ADDR_W(16), .CNT_W(16)) h0 ();
  hazard_if #(.REG_W(4), .NSRC(2), .ADDR_W(16), .CNT_W(16)) h1 ();
  hazard_if #(.REG_W(4), .NSRC(3), .ADDR_W(16), .CNT_W(16)) h2 ();

  hazard_unit_p #(.REG_W(4), .NSRC(2), .ADDR_W(16), .LOAD_STALL(1), .INT_FLUSH(1), .CNT_W(16))
    u0 (.CLK(CLK), .RST(RST), .hz(h0));
  hazard_unit_p #(.REG_W(4), .NSRC(2), .ADDR_W(16), .LOAD_STALL(3), .INT_FLUSH(2), .CNT_W(16))
    u1 (.CLK(CLK), .RST(RST), .hz(h1));
  hazard_unit_p #(.REG_W(4), .NSRC(3), .ADDR_W(16), .LOAD_STALL(1), .INT_FLUSH(1), .CNT_W(16))
    u2 (.CLK(CLK), .RST(RST), .hz(h2));

  logic [9:0] f0, f1, f2;
  assign f0 = {h0.stall_pc_o, h0.stall_if_o, h0.flush_if_o, h0.flush_id_o, h0.flush_ex_o,
               h0.jr_o, h0.prewrong_o, h0.precorrc_o, h0.isintzero_o, h0.int_ack_o};
  assign f1 = {h1.stall_pc_o, h1.stall_if_o, h1.flush_if_o, h1.flush_id_o, h1.flush_ex_o,
               h1.jr_o, h1.prewrong_o, h1.precorrc_o, h1.isintzero_o, h1.int_ack_o};
  assign f2 = {h2.stall_pc_o, h2.stall_if_o, h2.flush_if_o, h2.flush_id_o, h2.flush_ex_o,
               h2.jr_o, h2.prewrong_o, h2.precorrc_o, h2.isintzero_o, h2.int_ack_o};

  task automatic clr_all;
    h0.int_req_i = 1'b0; h0.epc_i = 16'h0000; h0.ram2_conflict_i = 1'b0; h0.memread_ex_i = 1'b0;
    h0.regdst_ex_i = 4'd0; h0.memread_mem_i = 1'b0; h0.regdst_mem_i = 4'd0; h0.regsrc_id_i = 8'h00;
    h0.srcvalid_id_i = 2'b00; h0.isjump_i = 1'b0; h0.isbranch_i = 1'b0; h0.prediction_i = 1'b0;
    h0.ifbranch_i = 1'b0;
    h1.int_req_i = 1'b0; h1.epc_i = 16'h0000; h1.ram2_conflict_i = 1'b0; h1.memread_ex_i = 1'b0;
    h1.regdst_ex_i = 4'd0; h1.memread_mem_i = 1'b0; h1.regdst_mem_i = 4'd0; h1.regsrc_id_i = 8'h00;
    h1.srcvalid_id_i = 2'b00; h1.isjump_i = 1'b0; h1.isbranch_i = 1'b0; h1.prediction_i = 1'b0;
    h1.ifbranch_i = 1'b0;
    h2.int_req_i = 1'b0; h2.epc_i = 16'h0000; h2.ram2_conflict_i = 1'b0; h2.memread_ex_i = 1'b0;
    h2.regdst_ex_i = 4'd0; h2.memread_mem_i = 1'b0; h2.regdst_mem_i = 4'd0; h2.regsrc_id_i = 12'h000;
    h2.srcvalid_id_i = 3'b000; h2.isjump_i = 1'b0; h2.isbranch_i = 1'b0; h2.prediction_i = 1'b0;
    h2.ifbranch_i = 1'b0;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    h0.int_req_i = 1'b1; h0.ram2_conflict_i = 1'b1; h0.isjump_i = 1'b1; h0.epc_i = 16'h1234;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (f0 !== 10'h000) begin errors++; $display("FAIL reset_flags got=%h exp=%h", f0, 10'h000); end
    checks++; if ({h0.epc_o, h0.stall_cnt_o, h0.mispred_cnt_o} !== 48'h0) begin
      errors++; $display("FAIL reset_regs epc=%h stall=%h mis=%h exp=0", h0.epc_o, h0.stall_cnt_o, h0.mispred_cnt_o);
    end
    step();
    RST = 1'b0;
    clr_all();
    @(negedge CLK);
    checks++; if (f0 !== 10'h000) begin errors++; $display("FAIL idle_flags got=%h exp=%h", f0, 10'h000); end
    checks++; if (h0.stall_cnt_o !== 16'h0000) begin errors++; $display("FAIL idle_cnt got=%h exp=0000", h0.stall_cnt_o); end
    step();
  endtask

  task automatic test_load_use;
    h0.memread_ex_i = 1'b1; h0.regdst_ex_i = 4'd3; h0.regsrc_id_i = {4'd3, 4'd1}; h0.srcvalid_id_i = 2'b11;
    @(negedge CLK);
    checks++; if (f0 !== 10'h340) begin errors++; $display("FAIL lu_stall got=%h exp=%h", f0, 10'h340); end
    step();
    clr_all();
    @(negedge CLK);
    checks++; if (f0 !== 10'h000) begin errors++; $display("FAIL lu_release got=%h exp=%h", f0, 10'h000); end
    checks++; if (h0.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", h0.stall_cnt_o); end
    step();
  endtask

  task automatic test_load_stall3;
    h1.memread_ex_i = 1'b1; h1.regdst_ex_i = 4'd3; h1.regsrc_id_i = {4'd3, 4'd1}; h1.srcvalid_id_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (f1 !== 10'h340) begin errors++; $display("FAIL ls3_stall%0d got=%h exp=%h", i, f1, 10'h340); end
      step();
      clr_all();
    end
    @(negedge CLK);
    checks++; if (f1 !== 10'h000) begin errors++; $display("FAIL ls3_release got=%h exp=%h", f1, 10'h000); end
    checks++; if (h1.stall_cnt_o !== 16'd3) begin errors++; $display("FAIL ls3_cnt got=%0d exp=3", h1.stall_cnt_o); end
    step();
  endtask

  task automatic test_int_in_lstall;
    h1.memread_ex_i = 1'b1; h1.regdst_ex_i = 4'd3; h1.regsrc_id_i = {4'd3, 4'd1}; h1.srcvalid_id_i = 2'b11;
    @(negedge CLK);
    checks++; if (f1 !== 10'h340) begin errors++; $display("FAIL int_pre_stall got=%h exp=%h", f1, 10'h340); end
    step();
    clr_all();
    h1.int_req_i = 1'b1; h1.epc_i = 16'h0042;
    @(negedge CLK);
    checks++; if (f1 !== 10'h0C1) begin errors++; $display("FAIL int_take got=%h exp=%h", f1, 10'h0C1); end
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++; if (f1 !== 10'h062) begin errors++; $display("FAIL int_window%0d got=%h exp=%h", i, f1, 10'h062); end
      checks++; if (h1.epc_o !== 16'h0042) begin errors++; $display("FAIL int_epc%0d got=%h exp=0042", i, h1.epc_o); end
      step();
    end
    @(negedge CLK);
    checks++; if (f1 !== 10'h000) begin errors++; $display("FAIL int_no_retake got=%h exp=%h", f1, 10'h000); end
    step();
    h1.int_req_i = 1'b0;
    step();
    h1.int_req_i = 1'b1; h1.epc_i = 16'h0077;
    @(negedge CLK);
    checks++; if (f1 !== 10'h0C1) begin errors++; $display("FAIL int_rearm got=%h exp=%h", f1, 10'h0C1); end
    step();
    h1.int_req_i = 1'b0;
    @(negedge CLK);
    checks++; if (h1.epc_o !== 16'h0077) begin errors++; $display("FAIL int_epc2 got=%h exp=0077", h1.epc_o); end
    repeat (2) step();
    @(negedge CLK);
    checks++; if (f1 !== 10'h000) begin errors++; $display("FAIL int_exit got=%h exp=%h", f1, 10'h000); end
    checks++; if (h1.stall_cnt_o !== 16'd4) begin errors++; $display("FAIL int_stall_cnt got=%0d exp=4", h1.stall_cnt_o); end
    step();
  endtask

  task automatic test_branch;
    h0.isbranch_i = 1'b1; h0.prediction_i = 1'b1; h0.ifbranch_i = 1'b0;
    h0.memread_mem_i = 1'b1; h0.regdst_mem_i = 4'd5; h0.regsrc_id_i = {4'd0, 4'd5}; h0.srcvalid_id_i = 2'b01;
    @(negedge CLK);
    checks++; if (f0 !== 10'h340) begin errors++; $display("FAIL br_stalled got=%h exp=%h", f0, 10'h340); end
    step();
    h0.memread_mem_i = 1'b0;
    @(negedge CLK);
    checks++; if (f0 !== 10'h088) begin errors++; $display("FAIL br_prewrong got=%h exp=%h", f0, 10'h088); end
    step();
    h0.ifbranch_i = 1'b1;
    @(negedge CLK);
    checks++; if (f0 !== 10'h004) begin errors++; $display("FAIL br_precorrc got=%h exp=%h", f0, 10'h004); end
    checks++; if (h0.mispred_cnt_o !== 16'd1) begin errors++; $display("FAIL br_mis_cnt got=%0d exp=1", h0.mispred_cnt_o); end
    step();
    clr_all();
    h0.isjump_i = 1'b1; h0.regsrc_id_i = {4'd0, 4'd7}; h0.srcvalid_id_i = 2'b01;
    @(negedge CLK);
    checks++; if (f0 !== 10'h090) begin errors++; $display("FAIL jr_redirect got=%h exp=%h", f0, 10'h090); end
    step();
    clr_all();
    @(negedge CLK);
    checks++; if (h0.stall_cnt_o !== 16'd2) begin errors++; $display("FAIL br_stall_cnt got=%0d exp=2", h0.stall_cnt_o); end
    step();
  endtask

  task automatic test_srcvalid;
    h0.memread_ex_i = 1'b1; h0.regdst_ex_i = 4'd6; h0.regsrc_id_i = {4'd6, 4'd2}; h0.srcvalid_id_i = 2'b01;
    @(negedge CLK);
    checks++; if (f0 !== 10'h000) begin errors++; $display("FAIL sv_masked got=%h exp=%h", f0, 10'h000); end
    step();
    h0.srcvalid_id_i = 2'b10;
    @(negedge CLK);
    checks++; if (f0 !== 10'h340) begin errors++; $display("FAIL sv_src1 got=%h exp=%h", f0, 10'h340); end
    step();
    clr_all();
    h2.memread_ex_i = 1'b1; h2.regdst_ex_i = 4'd9; h2.regsrc_id_i = {4'd9, 4'd1, 4'd2}; h2.srcvalid_id_i = 3'b100;
    @(negedge CLK);
    checks++; if (f2 !== 10'h340) begin errors++; $display("FAIL sv_src2 got=%h exp=%h", f2, 10'h340); end
    step();
    h2.srcvalid_id_i = 3'b011;
    @(negedge CLK);
    checks++; if (f2 !== 10'h000) begin errors++; $display("FAIL sv_src2_masked got=%h exp=%h", f2, 10'h000); end
    step();
    h2.regdst_ex_i = 4'd0; h2.regsrc_id_i = {4'd5, 4'd5, 4'd0}; h2.srcvalid_id_i = 3'b001;
    @(negedge CLK);
    checks++; if (f2 !== 10'h340) begin errors++; $display("FAIL sv_reg0 got=%h exp=%h", f2, 10'h340); end
    step();
    clr_all();
    @(negedge CLK);
    checks++; if (h2.stall_cnt_o !== 16'd2) begin errors++; $display("FAIL sv_cnt got=%0d exp=2", h2.stall_cnt_o); end
    step();
  endtask

  task automatic test_saturate;
    h2.ram2_conflict_i = 1'b1;
    @(negedge CLK);
    checks++; if (f2 !== 10'h340) begin errors++; $display("FAIL ram2_stall got=%h exp=%h", f2, 10'h340); end
    repeat (65532) @(posedge CLK);
    #1;
    checks++; if (h2.stall_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got=%h exp=FFFE", h2.stall_cnt_o); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (h2.stall_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hold%0d got=%h exp=FFFF", i, h2.stall_cnt_o); end
    end
  endtask

  task automatic test_rst_mid_int;
    h1.int_req_i = 1'b1; h1.epc_i = 16'h0099;
    @(negedge CLK);
    checks++; if (f1 !== 10'h0C1) begin errors++; $display("FAIL rst_int_take got=%h exp=%h", f1, 10'h0C1); end
    step();
    @(negedge CLK);
    checks++; if (f1 !== 10'h062) begin errors++; $display("FAIL rst_int_window got=%h exp=%h", f1, 10'h062); end
    RST = 1'b1;
    #1;
    checks++; if ({f1, f2} !== 20'h00000) begin errors++; $display("FAIL rst_flags got=%h/%h exp=0", f1, f2); end
    checks++; if ({h1.epc_o, h1.stall_cnt_o, h2.stall_cnt_o} !== 48'h0) begin
      errors++; $display("FAIL rst_regs epc=%h c1=%h c2=%h exp=0", h1.epc_o, h1.stall_cnt_o, h2.stall_cnt_o);
    end
    step();
    RST = 1'b0;
    h2.ram2_conflict_i = 1'b0;
    @(negedge CLK);
    checks++; if (f1 !== 10'h0C1) begin errors++; $display("FAIL rst_run_rearmed got=%h exp=%h", f1, 10'h0C1); end
    checks++; if ({h1.epc_o, h2.stall_cnt_o} !== 32'h0) begin errors++; $display("FAIL rst_cleared epc=%h c2=%h exp=0", h1.epc_o, h2.stall_cnt_o); end
    step();
    clr_all();
  endtask

  initial begin
    clr_all();
    test_reset();
    test_load_use();
    test_load_stall3();
    test_int_in_lstall();
    test_branch();
    test_srcvalid();
    test_saturate();
    test_rst_mid_int();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
